// File: rtl/acc_buf.sv
// acc_buf: accumulation partial-sum RAM plus bias RAM for the convolution
// datapath, with a sweep FSM that zeroes the accumulation RAM between tiles.
//
// Build option:
//   ACC_BUF_FWD_EN  defined   -> write-first forwarding on same-address
//                                accumulation read/write (outside a sweep)
//   ACC_BUF_FWD_EN  undefined -> read-first; no address comparator is built
//
// Memory contents are never reset; only registers and flags are.
module acc_buf #(
   parameter int AW = 9,
   parameter int DW = 26,
   parameter int DN = 7
) (
   input  logic                 clk,
   input  logic                 rst_n,
   // accumulation read port (every cycle)
   input  logic [AW-1:0]        acc_rd_addr,
   output logic [DW*DN-1:0]     acc_rd_data,
   // accumulation write port
   input  logic [AW-1:0]        acc_wr_addr,
   input  logic [DW*DN-1:0]     acc_wr_data,
   input  logic                 acc_wr_valid,
   // bias read port
   input  logic                 bias_rd_en,
   input  logic [AW-1:0]        bias_rd_addr,
   output logic [DW*DN-1:0]     bias_rd_data,
   // bias load port
   input  logic [AW-1:0]        bias_ld_addr,
   input  logic [DW*DN-1:0]     bias_ld_data,
   input  logic                 bias_ld_valid,
   output logic                 bias_ld_ready,
   // sweep control / status
   input  logic                 clr_start,
   output logic                 clr_busy,
   output logic                 clr_done,
   output logic                 wr_drop
);

   localparam int            W        = DW * DN;
   localparam int            DEPTH    = 2 ** AW;
   localparam logic [AW-1:0] CNT_LAST = {AW{1'b1}};
   localparam logic [AW-1:0] CNT_ZERO = {AW{1'b0}};
   localparam logic [AW-1:0] CNT_ONE  = AW'(1);
   localparam logic [W-1:0]  WORD_ZERO = {W{1'b0}};

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   // ------------------------------------------------------------------
   // Storage (no reset on the arrays themselves)
   // ------------------------------------------------------------------
   logic [W-1:0]  acc_mem  [DEPTH];
   logic [W-1:0]  bias_mem [DEPTH];

   // ------------------------------------------------------------------
   // Sweep FSM state and its next-state values
   // ------------------------------------------------------------------
   state_t        state_r;
   state_t        state_nxt_s;
   logic [AW-1:0] cnt_r;
   logic [AW-1:0] cnt_nxt_s;
   logic          wr_drop_r;
   logic          wr_drop_nxt_s;
   logic          done_r;
   logic          done_nxt_s;

   // ------------------------------------------------------------------
   // Accumulation RAM write-port mux and read-data path
   // ------------------------------------------------------------------
   logic          mem_we_s;
   logic [AW-1:0] mem_waddr_s;
   logic [W-1:0]  mem_wdata_s;
   logic [W-1:0]  rd_data_nxt_s;
   logic [W-1:0]  rd_data_r;

   // ------------------------------------------------------------------
   // Bias RAM
   // ------------------------------------------------------------------
   logic          bias_ld_fire_s;
   logic [W-1:0]  bias_rd_r;

   // Sweep FSM next-state: IDLE waits for clr_start, CLEAR walks every address once.
   always_comb begin
      state_nxt_s   = state_r;
      cnt_nxt_s     = cnt_r;
      wr_drop_nxt_s = wr_drop_r;
      done_nxt_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (clr_start) begin
               state_nxt_s   = ST_CLEAR;
               cnt_nxt_s     = CNT_ZERO;
               wr_drop_nxt_s = 1'b0;
            end else begin
               state_nxt_s   = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            // accumulator writes cannot land while the sweep owns the port
            if (acc_wr_valid) begin
               wr_drop_nxt_s = 1'b1;
            end else begin
               wr_drop_nxt_s = wr_drop_r;
            end
            // the last address is written on the exit edge; the counter
            // only wraps to zero as the sweep leaves CLEAR
            if (cnt_r == CNT_LAST) begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = CNT_ZERO;
               done_nxt_s  = 1'b1;
            end else begin
               state_nxt_s = ST_CLEAR;
               cnt_nxt_s   = cnt_r + CNT_ONE;
            end
         end
         default: begin
            state_nxt_s   = ST_IDLE;
            cnt_nxt_s     = CNT_ZERO;
            wr_drop_nxt_s = wr_drop_r;
         end
      endcase
   end

   // Sweep FSM and status registers; reset aborts a sweep without a done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         cnt_r     <= CNT_ZERO;
         wr_drop_r <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         cnt_r     <= cnt_nxt_s;
         wr_drop_r <= wr_drop_nxt_s;
         done_r    <= done_nxt_s;
      end
   end

   // Accumulation write-port mux: the sweep has priority and writes zero.
   always_comb begin
      mem_we_s    = 1'b0;
      mem_waddr_s = acc_wr_addr;
      mem_wdata_s = acc_wr_data;
      if (state_r == ST_CLEAR) begin
         mem_we_s    = 1'b1;
         mem_waddr_s = cnt_r;
         mem_wdata_s = WORD_ZERO;
      end else begin
         mem_we_s    = acc_wr_valid;
         mem_waddr_s = acc_wr_addr;
         mem_wdata_s = acc_wr_data;
      end
   end

   // Accumulation RAM write port.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         acc_mem[mem_waddr_s] <= mem_wdata_s;
      end
   end

   // Accumulation read data: zero for every cycle the sweep is active,
   // otherwise the addressed word (optionally bypassing a same-address write).
   always_comb begin
      rd_data_nxt_s = acc_mem[acc_rd_addr];
      if ((state_r == ST_CLEAR) || (state_nxt_s == ST_CLEAR)) begin
         rd_data_nxt_s = WORD_ZERO;
      end
`ifdef ACC_BUF_FWD_EN
      else if (acc_wr_valid && (acc_wr_addr == acc_rd_addr)) begin
         rd_data_nxt_s = acc_wr_data;
      end
`endif
      else begin
         rd_data_nxt_s = acc_mem[acc_rd_addr];
      end
   end

   // Accumulation read-data register (1-cycle latency).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_r <= WORD_ZERO;
      end else begin
         rd_data_r <= rd_data_nxt_s;
      end
   end

   // Bias port arbitration: the single port serves a read first, a load stalls.
   always_comb begin
      bias_ld_fire_s = 1'b0;
      if (bias_rd_en) begin
         bias_ld_fire_s = 1'b0;
      end else begin
         bias_ld_fire_s = bias_ld_valid;
      end
   end

   // Bias RAM load path.
   always_ff @(posedge clk) begin
      if (bias_ld_fire_s) begin
         bias_mem[bias_ld_addr] <= bias_ld_data;
      end
   end

   // Bias read-data register: updates only on a read request, holds otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bias_rd_r <= WORD_ZERO;
      end else if (bias_rd_en) begin
         bias_rd_r <= bias_mem[bias_rd_addr];
      end else begin
         bias_rd_r <= bias_rd_r;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign acc_rd_data   = rd_data_r;
   assign bias_rd_data  = bias_rd_r;
   assign bias_ld_ready = ~bias_rd_en;
   assign clr_busy      = (state_r == ST_CLEAR);
   assign clr_done      = done_r;
   assign wr_drop       = wr_drop_r;

endmodule
